decap_packet: RTL and testbench

Receive-side counterpart of the input-port packet encapsulator. It accepts a stream of 64-bit Aurora words, each carrying a 9-bit header (router ID, packet number, TTL) and a 55-bit payload. It checks packet sequencing and router-ID consistency, and reassembles the 19 payloads into one 1034-bit DFX word (1024 data + 10 address). The block sits between the Aurora RX user interface and the DFX write path of an output port, and presents the reassembled word with a valid/ready handshake.

---
 rtl/decap_packet.sv | 130 +++++++++++++
 tb/tb_decap_packet.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decap_packet.sv
// Aurora RX de-encapsulator: checks packet order and router ID, then reassembles
// NUMBER_PACKET payloads into one DFX word presented with a valid/ready handshake.
module decap_packet #(
    parameter int unsigned DATA_WIDTH             = 1024,
    parameter int unsigned ADDR_WIDTH             = 10,
    parameter int unsigned DATA_DFX_WIDTH         = DATA_WIDTH + ADDR_WIDTH,
    parameter int unsigned RECOGNIZE_ROUTER_WIDTH = 2,
    parameter int unsigned NUMBER_PACKET          = 19,
    parameter int unsigned TTL_WIDTH              = $clog2(3),
    parameter int unsigned HEADER_WIDTH           = RECOGNIZE_ROUTER_WIDTH
                                                    + $clog2(NUMBER_PACKET) + TTL_WIDTH,
    parameter int unsigned AURORA_DATA_WIDTH      = 64,
    parameter int unsigned PAYLOAD_WIDTH          = AURORA_DATA_WIDTH - HEADER_WIDTH
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [AURORA_DATA_WIDTH-1:0]      aurora_rx_data,
    input  logic                              aurora_rx_valid,
    output logic                              decap_ready,
    output logic [DATA_DFX_WIDTH-1:0]         data_dfx_recv,
    output logic [RECOGNIZE_ROUTER_WIDTH-1:0] router_id_recv,
    output logic [TTL_WIDTH-1:0]              ttl_recv,
    output logic                              data_decap_valid,
    input  logic                              dfx_ready,
    output logic                              decap_err
);
    localparam int unsigned PktW    = $clog2(NUMBER_PACKET);
    localparam int unsigned LastIdx = NUMBER_PACKET - 1;
    localparam int unsigned LastW   = DATA_DFX_WIDTH - LastIdx * PAYLOAD_WIDTH;

    typedef enum logic [1:0] {StIdle, StCollect, StDone} state_e;

    state_e                            state_q;
    logic [PktW-1:0]                   expected_q;
    logic [DATA_DFX_WIDTH-1:0]         data_q;
    logic [RECOGNIZE_ROUTER_WIDTH-1:0] id_q;
    logic [TTL_WIDTH-1:0]              ttl_q;
    logic                              valid_q;
    logic                              ready_q;
    logic                              err_q;

    logic [RECOGNIZE_ROUTER_WIDTH-1:0] rx_id;
    logic [PktW-1:0]                   rx_pkt;
    logic [TTL_WIDTH-1:0]              rx_ttl;
    logic [PAYLOAD_WIDTH-1:0]          rx_payload;
    logic                              accept;
    logic                              in_seq;
    logic                              store;
    logic                              is_last;

    assign rx_id      = aurora_rx_data[AURORA_DATA_WIDTH-1 -: RECOGNIZE_ROUTER_WIDTH];
    assign rx_pkt     = aurora_rx_data[AURORA_DATA_WIDTH-RECOGNIZE_ROUTER_WIDTH-1 -: PktW];
    assign rx_ttl     = aurora_rx_data[PAYLOAD_WIDTH +: TTL_WIDTH];
    assign rx_payload = aurora_rx_data[PAYLOAD_WIDTH-1:0];

    // Ready is gated by rst so it reads 0 while reset is held and 1 right after release.
    assign decap_ready = ready_q & ~rst;
    assign accept      = aurora_rx_valid & decap_ready;
    assign in_seq      = (state_q == StCollect) && (rx_pkt == expected_q) && (rx_id == id_q);
    assign store       = accept && ((rx_pkt == '0) || in_seq);
    assign is_last     = (rx_pkt == PktW'(LastIdx));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            expected_q <= '0;
            data_q     <= '0;
            id_q       <= '0;
            ttl_q      <= '0;
            valid_q    <= 1'b0;
            ready_q    <= 1'b1;
            err_q      <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                StIdle, StCollect: begin
                    if (accept) begin
                        if (rx_pkt == '0) begin
                            // A packet 0 mid-frame restarts the frame with this word.
                            err_q      <= (state_q == StCollect);
                            id_q       <= rx_id;
                            ttl_q      <= rx_ttl;
                            expected_q <= PktW'(1);
                            state_q    <= StCollect;
                        end else if (in_seq) begin
                            if (is_last) begin
                                expected_q <= '0;
                                state_q    <= StDone;
                                valid_q    <= 1'b1;
                                ready_q    <= 1'b0;
                            end else begin
                                expected_q <= expected_q + PktW'(1);
                            end
                        end else begin
                            err_q      <= 1'b1;
                            expected_q <= '0;
                            state_q    <= StIdle;
                        end
                    end
                end
                StDone: begin
                    if (dfx_ready) begin
                        state_q <= StIdle;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase

            if (store) begin
                for (int k = 0; k < int'(LastIdx); k++) begin
                    if (rx_pkt == PktW'(k)) begin
                        data_q[k*PAYLOAD_WIDTH +: PAYLOAD_WIDTH] <= rx_payload;
                    end
                end
                // The last word only fills the remaining top bits of the DFX word.
                if (is_last) begin
                    data_q[DATA_DFX_WIDTH-1 -: LastW] <= rx_payload[LastW-1:0];
                end
            end
        end
    end

    assign data_dfx_recv    = data_q;
    assign router_id_recv   = id_q;
    assign ttl_recv         = ttl_q;
    assign data_decap_valid = valid_q;
    assign decap_err        = err_q;
endmodule

// File: tb/tb_decap_packet.sv
// Self-checking bench for decap_packet: vector table, directed corner sequences and
// random traffic compared against a frame-level reference model.
module tb_decap_packet;
    localparam int DW = 1034;
    localparam int PW = 55;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [63:0]   rx_data = '0;
    logic          rx_valid = 1'b0;
    logic          dfx_ready = 1'b0;
    logic          decap_ready;
    logic [DW-1:0] data_dfx_recv;
    logic [1:0]    router_id_recv;
    logic [1:0]    ttl_recv;
    logic          data_decap_valid;
    logic          decap_err;

    decap_packet dut (
        .clk             (clk),
        .rst             (rst),
        .aurora_rx_data  (rx_data),
        .aurora_rx_valid (rx_valid),
        .decap_ready     (decap_ready),
        .data_dfx_recv   (data_dfx_recv),
        .router_id_recv  (router_id_recv),
        .ttl_recv        (ttl_recv),
        .data_decap_valid(data_decap_valid),
        .dfx_ready       (dfx_ready),
        .decap_err       (decap_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int err_seen = 0;
    bit last_acc;

    // Reference model: frame-level view of the receiver.
    bit            m_busy, m_done, m_err;
    int            m_next;
    logic [1:0]    m_id, m_ttl;
    logic [DW-1:0] m_data;

    typedef struct {
        bit         v;
        logic [1:0] id;
        int         pkt;
        logic [1:0] ttl;
        bit         e_err;
        logic [1:0] e_id;
        logic [1:0] e_ttl;
    } vec_t;
    vec_t tbl[9];

    function automatic logic [63:0] mk(input logic [1:0] id, input int pkt,
                                       input logic [1:0] ttl, input logic [54:0] pl);
        logic [4:0] p;
        p = pkt[4:0];
        return {id, p, ttl, pl};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_data(input string name, input logic [DW-1:0] exp);
        logic [54:0] a, e;
        n_checks++;
        if (data_dfx_recv !== exp) begin
            n_fail++;
            for (int k = 0; k < 19; k++) begin
                a = 55'(data_dfx_recv >> (k * PW));
                e = 55'(exp >> (k * PW));
                if (a !== e) begin
                    $display("FAIL %s: slice %0d got %0h expected %0h at %0t",
                             name, k, a, e, $time);
                    break;
                end
            end
        end
    endtask

    task automatic put(input int k, input logic [54:0] pl);
        for (int b = 0; b < PW; b++) begin
            if (k * PW + b < DW) m_data[k*PW+b] = pl[b];
        end
    endtask

    task automatic model_update();
        int pkt;
        logic [1:0] id;
        last_acc = 1'b0;
        if (rst) begin
            m_busy = 0; m_done = 0; m_err = 0; m_next = 0;
            m_id = '0; m_ttl = '0; m_data = '0;
            return;
        end
        m_err = 0;
        if (m_done) begin
            if (dfx_ready) m_done = 0;
        end else if (rx_valid) begin
            last_acc = 1'b1;
            pkt = int'(rx_data[61:57]);
            id  = rx_data[63:62];
            if (pkt == 0) begin
                m_err = m_busy;
                m_busy = 1; m_next = 1; m_id = id; m_ttl = rx_data[56:55];
                put(0, rx_data[54:0]);
            end else if (m_busy && pkt == m_next && id == m_id) begin
                put(pkt, rx_data[54:0]);
                m_next++;
                if (pkt == 18) begin
                    m_busy = 0; m_done = 1;
                end
            end else begin
                m_err = 1; m_busy = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        if (decap_err === 1'b1) err_seen++;
        chk("ready", decap_ready, (rst || m_done) ? 0 : 1);
        chk("valid", data_decap_valid, m_done);
        chk("err", decap_err, m_err);
        chk("router_id", router_id_recv, m_id);
        chk("ttl", ttl_recv, m_ttl);
        chk_data("data", m_data);
    endtask

    task automatic send(input logic [1:0] id, input int pkt, input logic [1:0] ttl,
                        input logic [54:0] pl);
        rx_valid = 1'b1;
        rx_data  = mk(id, pkt, ttl, pl);
        tick();
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int src_pkt;
        logic [1:0] src_id, src_ttl;
        bit pending;

        tbl[0] = '{1, 2'd0, 7, 2'd0, 1, 2'd0, 2'd0};  // stray word in idle
        tbl[1] = '{0, 2'd0, 0, 2'd0, 0, 2'd0, 2'd0};
        tbl[2] = '{1, 2'd2, 0, 2'd1, 0, 2'd2, 2'd1};  // frame start
        tbl[3] = '{1, 2'd2, 1, 2'd3, 0, 2'd2, 2'd1};  // TTL of later words ignored
        tbl[4] = '{1, 2'd2, 3, 2'd0, 1, 2'd2, 2'd1};  // skipped packet
        tbl[5] = '{1, 2'd2, 1, 2'd0, 1, 2'd2, 2'd1};  // now idle again
        tbl[6] = '{1, 2'd3, 0, 2'd2, 0, 2'd3, 2'd2};
        tbl[7] = '{1, 2'd1, 1, 2'd2, 1, 2'd3, 2'd2};  // router mismatch
        tbl[8] = '{0, 2'd0, 0, 2'd0, 0, 2'd3, 2'd2};

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        chk("rst_ready", decap_ready, 0);
        chk("rst_valid", data_decap_valid, 0);
        chk("rst_err", decap_err, 0);
        chk("rst_data_lo", data_dfx_recv[63:0], 0);
        rst = 1'b0;
        #1;
        chk("rst_release_ready", decap_ready, 1);

        // Vector table
        for (int i = 0; i < 9; i++) begin
            rx_valid = tbl[i].v;
            rx_data  = mk(tbl[i].id, tbl[i].pkt, tbl[i].ttl, 55'(i + 1));
            tick();
            chk("tbl_err", decap_err, tbl[i].e_err);
            chk("tbl_ready", decap_ready, 1);
            chk("tbl_valid", data_decap_valid, 0);
            chk("tbl_id", router_id_recv, tbl[i].e_id);
            chk("tbl_ttl", ttl_recv, tbl[i].e_ttl);
        end

        // Nominal frame, then backpressure
        dfx_ready = 1'b0;
        err_seen = 0;
        for (int k = 0; k < 19; k++) send(2'b10, k, 2'b01, 55'(k + 1));
        chk("nom_valid", data_decap_valid, 1);
        chk("nom_ready", decap_ready, 0);
        for (int k = 0; k < 18; k++) chk("nom_slice", data_dfx_recv[k*PW +: PW], k + 1);
        chk("nom_top", data_dfx_recv[1033:990], 19);
        chk("nom_id", router_id_recv, 2'b10);
        chk("nom_ttl", ttl_recv, 2'b01);
        rx_valid = 1'b1;
        rx_data  = mk(2'b01, 0, 2'b11, 55'h77);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_ready", decap_ready, 0);
            chk("bp_valid", data_decap_valid, 1);
            chk("bp_id", router_id_recv, 2'b10);
        end
        dfx_ready = 1'b1;
        tick();
        chk("hs_valid", data_decap_valid, 0);
        chk("hs_ready", decap_ready, 1);
        chk("hs_id", router_id_recv, 2'b10);
        idle(1);
        chk("nom_err_count", err_seen, 0);

        // Sequence error then a clean frame
        err_seen = 0;
        send(2'b01, 0, 2'b00, 55'h100);
        send(2'b01, 1, 2'b00, 55'h101);
        send(2'b01, 2, 2'b00, 55'h102);
        send(2'b01, 4, 2'b00, 55'h104);
        chk("seq_err", decap_err, 1);
        idle(1);
        chk("seq_err_once", err_seen, 1);
        for (int k = 0; k < 19; k++) send(2'b01, k, 2'b10, 55'(k + 55'h5000));
        chk("seq_valid", data_decap_valid, 1);
        chk("seq_top", data_dfx_recv[1033:990], 44'h5012);
        idle(2);

        // Premature restart
        err_seen = 0;
        for (int k = 0; k < 6; k++) send(2'b11, k, 2'b00, 55'(100 + k));
        for (int k = 0; k < 19; k++) send(2'b00, k, 2'b10, 55'(200 + k));
        chk("pre_err_count", err_seen, 1);
        chk("pre_valid", data_decap_valid, 1);
        for (int k = 0; k < 18; k++) chk("pre_slice", data_dfx_recv[k*PW +: PW], 200 + k);
        chk("pre_top", data_dfx_recv[1033:990], 218);
        chk("pre_id", router_id_recv, 2'b00);
        idle(2);

        // Router ID change mid-frame
        for (int k = 0; k < 3; k++) send(2'b10, k, 2'b01, 55'(k));
        send(2'b11, 3, 2'b01, 55'h3);
        chk("rid_err", decap_err, 1);
        idle(3);
        chk("rid_valid", data_decap_valid, 0);

        // Reset mid-frame, then stray packet 7
        for (int k = 0; k < 11; k++) send(2'b01, k, 2'b11, 55'h1234 + 55'(k));
        rst = 1'b1;
        tick();
        chk("mrst_data", (data_dfx_recv == '0) ? 1 : 0, 1);
        chk("mrst_id", router_id_recv, 0);
        chk("mrst_ttl", ttl_recv, 0);
        chk("mrst_ready", decap_ready, 0);
        rst = 1'b0;
        rx_valid = 1'b0;
        #1;
        chk("mrst_release_ready", decap_ready, 1);
        send(2'b01, 7, 2'b11, 55'h7);
        chk("stray_err", decap_err, 1);
        chk("stray_ready", decap_ready, 1);
        chk("stray_valid", data_decap_valid, 0);
        idle(1);

        // Random traffic against the model
        src_pkt = 0;
        src_id  = 2'($urandom_range(3));
        src_ttl = 2'($urandom_range(3));
        pending = 0;
        for (int c = 0; c < 4000; c++) begin
            if (!pending && $urandom_range(99) < 80) begin
                int p;
                logic [1:0] id;
                logic [54:0] pl;
                p  = src_pkt;
                id = src_id;
                if ($urandom_range(99) < 3) p = $urandom_range(20);
                if ($urandom_range(99) < 2) id = ~id;
                pl = {23'($urandom), $urandom};
                rx_data = mk(id, p, src_ttl, pl);
                pending = 1;
            end
            rx_valid  = pending;
            dfx_ready = ($urandom_range(99) < 60);
            rst       = ($urandom_range(999) < 2);
            tick();
            if (last_acc) begin
                pending = 0;
                if (m_busy) begin
                    src_pkt = m_next;
                end else begin
                    src_pkt = 0;
                    src_id  = 2'($urandom_range(3));
                    src_ttl = 2'($urandom_range(3));
                end
            end
        end
        rst = 1'b0;
        dfx_ready = 1'b1;
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
